// File: rtl/dex_core_if.sv
// Fetch <-> dex_core boundary: instruction stream in, redirect and write-back observation out.
// No back-pressure: one instruction (inst, pc_n) is consumed every clock; outputs are always valid.
interface dex_core_if;
  logic [31:0] pc_n;
  logic [31:0] inst;
  logic [31:0] pc_jmp;
  logic        isjmp;
  logic        wb_en;
  logic [2:0]  wb_dst;
  logic [31:0] wb_data;

  modport master (
    output pc_n, inst,
    input  pc_jmp, isjmp, wb_en, wb_dst, wb_data
  );

  modport slave (
    input  pc_n, inst,
    output pc_jmp, isjmp, wb_en, wb_dst, wb_data
  );
endinterface

// File: rtl/dex_core.sv
// dex_core: ID/EX/MEM/WB stages of a 5-stage in-order 32-bit pipeline with 8x32 RF and 256-word data memory.
// Optional macro RF_BYPASS_EN: an RF read of the register being written back returns wb_data in the same cycle.
module dex_core (
  input  logic      clk,
  input  logic      rst_n,
  dex_core_if.slave bus
);
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND  = 4'h3,
    OP_OR   = 4'h4, OP_XOR = 4'h5, OP_SLT = 4'h6, OP_SHL  = 4'h7,
    OP_SHR  = 4'h8, OP_ADDI = 4'h9, OP_LW = 4'hA, OP_SW   = 4'hB,
    OP_BEQ  = 4'hC, OP_JMP = 4'hD, OP_LUI = 4'hE, OP_NOP2 = 4'hF
  } op_e;

  // IF/ID
  logic [31:0] r_ifid_inst, r_ifid_pc_n;
  // ID/EX
  logic [31:0] r_idex_pc_n, r_idex_r1, r_idex_r2, r_idex_imm;
  logic [2:0]  r_idex_rd;
  op_e         r_idex_ex;
  logic [2:0]  r_idex_mem;
  logic [1:0]  r_idex_wb;
  // EX/MEM
  logic [31:0] r_exmem_alu, r_exmem_r2;
  logic [2:0]  r_exmem_rd;
  logic [1:0]  r_exmem_mem;
  logic [1:0]  r_exmem_wb;
  // MEM/WB
  logic [31:0] r_memwb_rdata, r_memwb_alu;
  logic [2:0]  r_memwb_rd;
  logic [1:0]  r_memwb_wb;

  logic [31:0] r_rf [8];
  logic [31:0] r_dmem [256];

  op_e         w_op;
  logic [2:0]  w_rd, w_rs1, w_rs2;
  logic [31:0] w_imm, w_rs1_val, w_rs2_val;
  logic [2:0]  w_mem;
  logic [1:0]  w_wb;
  logic [31:0] w_alu_b, w_alu, w_mem_rdata;
  logic        w_wb_en;
  logic [2:0]  w_wb_dst;
  logic [31:0] w_wb_data;
  logic        w_unused;

  assign w_op     = op_e'(r_ifid_inst[31:28]);
  assign w_rd     = r_ifid_inst[21:19];
  assign w_rs1    = r_ifid_inst[18:16];
  assign w_rs2    = r_ifid_inst[15:13];
  assign w_imm    = {{16{r_ifid_inst[15]}}, r_ifid_inst[15:0]};
  assign w_unused = ^r_ifid_inst[27:22];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_inst <= '0;
      r_ifid_pc_n <= '0;
    end else begin
      r_ifid_inst <= bus.inst;
      r_ifid_pc_n <= bus.pc_n;
    end
  end

  // Register-file read ports; r0 is hard-wired to zero on the read side.
  always_comb begin
    w_rs1_val = r_rf[w_rs1];
    w_rs2_val = r_rf[w_rs2];
`ifdef RF_BYPASS_EN
    if (w_wb_en && (w_wb_dst != 3'd0) && (w_wb_dst == w_rs1)) w_rs1_val = w_wb_data;
    if (w_wb_en && (w_wb_dst != 3'd0) && (w_wb_dst == w_rs2)) w_rs2_val = w_wb_data;
`endif
    if (w_rs1 == 3'd0) w_rs1_val = '0;
    if (w_rs2 == 3'd0) w_rs2_val = '0;
  end

  // Control groups: MEM = {mem_write, mem_read, is_jump}, WB = {reg_write, mem_to_reg}.
  always_comb begin
    w_mem = {w_op == OP_SW, w_op == OP_LW, (w_op == OP_BEQ) || (w_op == OP_JMP)};
    case (w_op)
      OP_NOP, OP_SW, OP_BEQ, OP_JMP, OP_NOP2: w_wb = 2'b00;
      OP_LW:                                  w_wb = 2'b11;
      default:                                w_wb = 2'b10;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex_pc_n <= '0;
      r_idex_r1   <= '0;
      r_idex_r2   <= '0;
      r_idex_imm  <= '0;
      r_idex_rd   <= '0;
      r_idex_ex   <= OP_NOP;
      r_idex_mem  <= '0;
      r_idex_wb   <= '0;
    end else begin
      r_idex_pc_n <= r_ifid_pc_n;
      r_idex_r1   <= w_rs1_val;
      r_idex_r2   <= w_rs2_val;
      r_idex_imm  <= w_imm;
      r_idex_rd   <= w_rd;
      r_idex_ex   <= w_op;
      r_idex_mem  <= w_mem;
      r_idex_wb   <= w_wb;
    end
  end

  // Redirect is resolved from ID/EX; the two following instructions still execute.
  assign bus.pc_jmp = r_idex_pc_n + (r_idex_imm << 2);
  assign bus.isjmp  = r_idex_mem[0] &&
                      ((r_idex_ex == OP_JMP) || ((r_idex_ex == OP_BEQ) && (r_idex_r1 == r_idex_r2)));

  always_comb begin
    w_alu_b = r_idex_r2;
    if ((r_idex_ex == OP_ADDI) || (r_idex_ex == OP_LW) || (r_idex_ex == OP_SW)) w_alu_b = r_idex_imm;
    case (r_idex_ex)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: w_alu = r_idex_r1 + w_alu_b;
      OP_SUB: w_alu = r_idex_r1 - r_idex_r2;
      OP_AND: w_alu = r_idex_r1 & r_idex_r2;
      OP_OR:  w_alu = r_idex_r1 | r_idex_r2;
      OP_XOR: w_alu = r_idex_r1 ^ r_idex_r2;
      OP_SLT: w_alu = {31'b0, $signed(r_idex_r1) < $signed(r_idex_r2)};
      OP_SHL: w_alu = r_idex_r1 << r_idex_r2[4:0];
      OP_SHR: w_alu = r_idex_r1 >> r_idex_r2[4:0];
      OP_LUI: w_alu = {r_idex_imm[15:0], 16'h0000};
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exmem_alu <= '0;
      r_exmem_r2  <= '0;
      r_exmem_rd  <= '0;
      r_exmem_mem <= '0;
      r_exmem_wb  <= '0;
    end else begin
      r_exmem_alu <= w_alu;
      r_exmem_r2  <= r_idex_r2;
      r_exmem_rd  <= r_idex_rd;
      r_exmem_mem <= r_idex_mem[2:1];
      r_exmem_wb  <= r_idex_wb;
    end
  end

  // Word-addressed by alu[9:2]; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && r_exmem_mem[1]) r_dmem[r_exmem_alu[9:2]] <= r_exmem_r2;
  end

  assign w_mem_rdata = r_exmem_mem[0] ? r_dmem[r_exmem_alu[9:2]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memwb_rdata <= '0;
      r_memwb_alu   <= '0;
      r_memwb_rd    <= '0;
      r_memwb_wb    <= '0;
    end else begin
      r_memwb_rdata <= w_mem_rdata;
      r_memwb_alu   <= r_exmem_alu;
      r_memwb_rd    <= r_exmem_rd;
      r_memwb_wb    <= r_exmem_wb;
    end
  end

  assign w_wb_en   = r_memwb_wb[1];
  assign w_wb_dst  = r_memwb_rd;
  assign w_wb_data = r_memwb_wb[0] ? r_memwb_rdata : r_memwb_alu;

  assign bus.wb_en   = w_wb_en;
  assign bus.wb_dst  = w_wb_dst;
  assign bus.wb_data = w_wb_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else if (w_wb_en && (w_wb_dst != 3'd0)) begin
      r_rf[w_wb_dst] <= w_wb_data;
    end
  end
endmodule

// File: tb/tb_dex_core.sv
// Bench for dex_core: ISA-level model with pipeline-timing windows, per-cycle compare, literal program checks.
module tb_dex_core;
  localparam int DEPTH = 512;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dex_core_if bus ();
  dex_core dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- model state ----------------
  logic [31:0] m_rf [8];
  logic [31:0] m_mem [256];
  logic        res_en [DEPTH];
  logic [2:0]  res_dst [DEPTH];
  logic [31:0] res_data [DEPTH];
  logic        ej_v [DEPTH];
  logic        ej_isjmp [DEPTH];
  logic [31:0] ej_pc [DEPTH];
  logic        ew_v [DEPTH];
  logic        ew_en [DEPTH];
  logic        ew_chk [DEPTH];
  logic [2:0]  ew_dst [DEPTH];
  logic [31:0] ew_data [DEPTH];
  int          seq;
  logic [31:0] pc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [34:0] wb_obs_q[$];
  logic [34:0] exp_q[$];
  logic [31:0] jmp_obs_q[$];
  logic [31:0] jexp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rr(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, 6'b0, rd, rs1, rs2, 13'b0};
  endfunction

  function automatic logic [31:0] ri(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [15:0] imm);
    return {op, 6'b0, rd, rs1, imm};
  endfunction

  // Register value seen by instruction s while it sits in decode.
  function automatic logic [31:0] rd_reg(input logic [2:0] r, input int s);
    if (r == 3'd0) return 32'd0;
    if (BYP && s >= 3 && res_en[s-3] && res_dst[s-3] == r) return res_data[s-3];
    return m_rf[r];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] ins, input logic [31:0] pcn);
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [31:0] imm, a, b, r, addr;
    logic        we, tk;
    int          s;
    s = seq;
    if (s >= 4 && res_en[s-4] && res_dst[s-4] != 3'd0) m_rf[res_dst[s-4]] = res_data[s-4];
    op  = ins[31:28];
    rd  = ins[21:19];
    rs1 = ins[18:16];
    rs2 = ins[15:13];
    imm = {{16{ins[15]}}, ins[15:0]};
    a = rd_reg(rs1, s);
    b = rd_reg(rs2, s);
    addr = a + imm;
    r = 32'd0;
    we = 1'b1;
    tk = 1'b0;
    case (op)
      4'h1: r = a + b;
      4'h2: r = a - b;
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h7: r = a << b[4:0];
      4'h8: r = a >> b[4:0];
      4'h9: r = addr;
      4'hA: r = m_mem[addr[9:2]];
      4'hB: begin m_mem[addr[9:2]] = b; we = 1'b0; end
      4'hC: begin we = 1'b0; tk = (a == b); end
      4'hD: begin we = 1'b0; tk = 1'b1; end
      4'hE: r = {ins[15:0], 16'h0000};
      default: we = 1'b0;
    endcase
    res_en[s] = we;
    res_dst[s] = rd;
    res_data[s] = r;
    if (s + 4 < DEPTH) begin
      ej_v[s+2] = 1'b1;
      ej_isjmp[s+2] = tk;
      ej_pc[s+2] = pcn + (imm << 2);
      ew_v[s+4] = 1'b1;
      ew_en[s+4] = we;
      ew_chk[s+4] = we;
      ew_dst[s+4] = rd;
      ew_data[s+4] = r;
    end
    bus.inst = ins;
    bus.pc_n = pcn;
    @(posedge clk);
    #1;
    seq++;
  endtask

  task automatic go(input logic [31:0] ins);
    issue(ins, pc);
    pc = pc + 32'd4;
  endtask

  task automatic drain(input int n);
    repeat (n) go(32'h0000_0000);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    seq = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      res_en[i] = 1'b0; ej_v[i] = 1'b0; ew_v[i] = 1'b0;
      ew_en[i] = 1'b0; ew_chk[i] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      ej_v[i] = 1'b1; ej_isjmp[i] = 1'b0; ej_pc[i] = 32'd0;
    end
    for (int i = 0; i < 4; i++) begin
      ew_v[i] = 1'b1; ew_en[i] = 1'b0; ew_chk[i] = (i < 2);
      ew_dst[i] = 3'd0; ew_data[i] = 32'd0;
    end
    repeat (n) begin
      bus.inst = $urandom;
      bus.pc_n = $urandom;
      @(posedge clk);
      #1;
    end
    bus.inst = 32'd0;
    bus.pc_n = 32'd0;
    rst_n = 1'b1;
  endtask

  task automatic check_wb(input string nm);
    chk({nm, "_count"}, 32'(wb_obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wb_obs_q.size(); i++) begin
      chk($sformatf("%s_dst%0d", nm, i), 32'(wb_obs_q[i][34:32]), 32'(exp_q[i][34:32]));
      chk($sformatf("%s_data%0d", nm, i), wb_obs_q[i][31:0], exp_q[i][31:0]);
    end
    wb_obs_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [34:0] e(input logic [2:0] d, input logic [31:0] v);
    return {d, v};
  endfunction

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_isjmp", 32'(bus.isjmp), 32'd0);
      chk("rst_pc_jmp", bus.pc_jmp, 32'd0);
      chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
      chk("rst_wb_dst", 32'(bus.wb_dst), 32'd0);
      chk("rst_wb_data", bus.wb_data, 32'd0);
    end else if (cyc < DEPTH) begin
      if (ej_v[cyc]) begin
        chk($sformatf("isjmp@%0d", cyc), 32'(bus.isjmp), 32'(ej_isjmp[cyc]));
        chk($sformatf("pc_jmp@%0d", cyc), bus.pc_jmp, ej_pc[cyc]);
        if (bus.isjmp) jmp_obs_q.push_back(bus.pc_jmp);
      end
      if (ew_v[cyc]) begin
        chk($sformatf("wb_en@%0d", cyc), 32'(bus.wb_en), 32'(ew_en[cyc]));
        if (ew_chk[cyc]) begin
          chk($sformatf("wb_dst@%0d", cyc), 32'(bus.wb_dst), 32'(ew_dst[cyc]));
          chk($sformatf("wb_data@%0d", cyc), bus.wb_data, ew_data[cyc]);
        end
        if (bus.wb_en) wb_obs_q.push_back({bus.wb_dst, bus.wb_data});
      end
    end
  end

  // ---------------- directed program ----------------
  initial begin
    bus.inst = 32'd0;
    bus.pc_n = 32'd0;
    pc = 32'h0000_1000;
    for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;

    // Reset with random instructions on the input, then read every register back.
    do_reset(2);
    for (int k = 1; k < 8; k++) begin
      go(rr(4'h1, 3'(k), 3'(k), 3'd0));
      exp_q.push_back(e(3'(k), 32'd0));
    end
    drain(5);
    check_wb("reset_regs");

    // ALU chain.
    go(ri(4'h9, 3'd1, 3'd0, 16'd5));
    go(ri(4'h9, 3'd2, 3'd0, 16'hFFFD));
    drain(3);
    go(rr(4'h1, 3'd3, 3'd1, 3'd2));
    go(rr(4'h2, 3'd4, 3'd1, 3'd2));
    go(rr(4'h6, 3'd5, 3'd2, 3'd1));
    go(rr(4'h3, 3'd6, 3'd1, 3'd2));
    go(rr(4'h4, 3'd6, 3'd1, 3'd2));
    go(rr(4'h5, 3'd6, 3'd1, 3'd2));
    go(rr(4'h7, 3'd7, 3'd1, 3'd1));
    go(rr(4'h8, 3'd7, 3'd2, 3'd1));
    go(32'hF03F_FFFF);
    drain(5);
    exp_q.push_back(e(3'd1, 32'd5));
    exp_q.push_back(e(3'd2, 32'hFFFF_FFFD));
    exp_q.push_back(e(3'd3, 32'd2));
    exp_q.push_back(e(3'd4, 32'd8));
    exp_q.push_back(e(3'd5, 32'd1));
    exp_q.push_back(e(3'd6, 32'd5));
    exp_q.push_back(e(3'd6, 32'hFFFF_FFFD));
    exp_q.push_back(e(3'd6, 32'hFFFF_FFF8));
    exp_q.push_back(e(3'd7, 32'h0000_00A0));
    exp_q.push_back(e(3'd7, 32'h07FF_FFFF));
    check_wb("alu_chain");

    // Reset with writes still in flight: they must never land.
    go(ri(4'h9, 3'd7, 3'd0, 16'h0055));
    go(ri(4'h9, 3'd6, 3'd0, 16'h0066));
    do_reset(1);
    wb_obs_q.delete();
    for (int k = 1; k < 8; k++) begin
      go(rr(4'h1, 3'(k), 3'(k), 3'd0));
      exp_q.push_back(e(3'(k), 32'd0));
    end
    drain(5);
    check_wb("midreset_regs");

    // Producer/consumer two slots apart.
    go(ri(4'h9, 3'd1, 3'd0, 16'd9));
    drain(2);
    go(rr(4'h1, 3'd2, 3'd1, 3'd0));
    drain(5);
    exp_q.push_back(e(3'd1, 32'd9));
    exp_q.push_back(e(3'd2, BYP ? 32'd9 : 32'd0));
    check_wb("bypass");

    // r0 write is visible on the wb port but never stored or bypassed.
    go(ri(4'h9, 3'd0, 3'd0, 16'd7));
    drain(2);
    go(rr(4'h1, 3'd5, 3'd0, 3'd0));
    drain(2);
    go(rr(4'h1, 3'd6, 3'd0, 3'd0));
    drain(5);
    exp_q.push_back(e(3'd0, 32'd7));
    exp_q.push_back(e(3'd5, 32'd0));
    exp_q.push_back(e(3'd6, 32'd0));
    check_wb("r0");

    // Store then load, including an aliased address (0x448 -> same word as 0x48).
    go(ri(4'h9, 3'd1, 3'd0, 16'h0040));
    go(ri(4'hE, 3'd2, 3'd0, 16'hDEAE));
    drain(3);
    go(ri(4'h9, 3'd2, 3'd2, 16'hBEEF));
    drain(3);
    go(ri(4'hB, 3'd0, 3'd1, 16'h4008));
    drain(3);
    go(ri(4'hA, 3'd3, 3'd1, 16'h0008));
    go(ri(4'hA, 3'd4, 3'd1, 16'h0408));
    drain(5);
    exp_q.push_back(e(3'd1, 32'h0000_0040));
    exp_q.push_back(e(3'd2, 32'hDEAE_0000));
    exp_q.push_back(e(3'd2, 32'hDEAD_BEEF));
    exp_q.push_back(e(3'd3, 32'hDEAD_BEEF));
    exp_q.push_back(e(3'd4, 32'hDEAD_BEEF));
    check_wb("memory");

    // Branches: taken BEQ, untaken BEQ, taken BEQ on equal non-zero regs, backward JMP.
    jmp_obs_q.delete();
    issue(ri(4'hC, 3'd0, 3'd0, 16'h0004), 32'h0000_0100);
    issue(ri(4'hC, 3'd0, 3'd1, 16'h0004), 32'h0000_0104);
    issue(ri(4'hC, 3'd0, 3'd1, 16'h2004), 32'h0000_0200);
    issue(ri(4'hD, 3'd0, 3'd0, 16'hFFFF), 32'h0000_0100);
    drain(4);
    jexp_q.push_back(32'h0000_0110);
    jexp_q.push_back(32'h0000_8210);
    jexp_q.push_back(32'h0000_00FC);
    chk("branch_count", 32'(jmp_obs_q.size()), 32'(jexp_q.size()));
    for (int i = 0; i < jexp_q.size() && i < jmp_obs_q.size(); i++)
      chk($sformatf("branch_target%0d", i), jmp_obs_q[i], jexp_q[i]);
    check_wb("branch_nowb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dex_core.md
# dex_core

Decode/execute/memory/write-back datapath of the 5-stage in-order 32-bit pipeline. Accepts one fetched instruction and its PC+4 per clock from the fetch stage. Internally it holds the IF/ID, ID/EX, EX/MEM and MEM/WB registers, an 8×32 register file, the ALU/branch unit, a 256-word data memory and the write-back mux. It returns the redirect target and taken flag to fetch, and exposes the write-back port for observation.

## Interface
- No parameters.
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_n  in  32  PC+4 of the fetched instruction.
- inst  in  32  fetched instruction.
- pc_jmp  out  32  redirect target; combinational from ID/EX.
- isjmp  out  1  redirect taken; combinational from ID/EX.
- wb_en  out  1  register-file write enable this cycle.
- wb_dst  out  3  destination register.
- wb_data  out  32  write-back data.

## Operation
- Instruction fields:
  - op = inst[31:28]
  - rd = inst[21:19]
  - rs1 = inst[18:16]
  - rs2 = inst[15:13]
  - imm = sign-extended inst[15:0]
- Opcodes:
  - 0 NOP
  - 1 ADD: rd = rs1 + rs2
  - 2 SUB: rd = rs1 − rs2
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SLT: signed, result 1/0
  - 7 SHL: rd = rs1 << rs2[4:0]
  - 8 SHR: logical
  - 9 ADDI: rd = rs1 + imm
  - A LW: rd = mem[rs1 + imm]
  - B SW: mem[rs1 + imm] = rs2
  - C BEQ: taken if rs1 == rs2
  - D JMP: always taken
  - E LUI: rd = inst[15:0] << 16
  - F: NOP
- Decode produces three control groups:
  - EX[3:0]: ALU op.
  - MEM[2:0]: {mem_write, mem_read, is_jump}.
  - WB[1:0]: {reg_write, mem_to_reg}.
  - NOP, SW, BEQ and JMP have reg_write = 0.
- Branch/jump target: pc_jmp = idex_pc_n + (imm << 2).
- isjmp:
  - JMP: is_jump.
  - BEQ: is_jump AND (R1 == R2).
  - All other ops: 0.
- Arithmetic is 32-bit wrap-around. Overflow is ignored.
- Data memory: 256 × 32-bit words, addressed by ALU result[9:2]. Bits [1:0] and [31:10] are ignored, so addresses wrap.
  - Write: synchronous on posedge when mem_write.
  - Read: combinational, captured into MEM/WB.
- Write-back: wb_data = mem_to_reg ? MEM/WB read data : MEM/WB ALU result.
  - wb_en = reg_write.
  - The register file is written on posedge.
- Register file: r0 reads 0 and writes to it are discarded. Two combinational read ports.
- No hazard detection, no forwarding, no flush:
  - Software inserts 3 independent instructions between a producer and its consumer; 2 with the bypass feature enabled.
  - The two instructions following a taken BEQ/JMP always execute (delay slots).

## Timing
- Instruction presented in cycle t:
  - Captured into IF/ID at edge t.
  - Into ID/EX at t+1; isjmp/pc_jmp valid during cycle t+1..t+2.
  - Into EX/MEM at t+2; SW writes memory at edge t+3.
  - Into MEM/WB at t+3; register file written at edge t+4.
  - wb_* valid during cycle t+3..t+4.
- Reset (async assert, sync to clk by construction on release):
  - All pipeline registers clear to 0, which is a NOP encoding.
  - All registers r0–r7 clear to 0.
  - Outputs isjmp = 0, wb_en = 0, wb_dst = 0, wb_data = 0.
  - pc_jmp = 0 (0 + 0).
  - Data memory is not reset; it initialises to 0 at time zero.
- Reset asserted mid-operation discards all in-flight instructions. A write-back or store due on that edge does not occur.
- Simultaneous register write and read of the same register in one cycle: the read returns the old value unless bypass is enabled.

## Configuration
- Macro RF_BYPASS_EN.
  - Defined: a register-file read whose address equals the write-back destination while wb_en = 1 (and dst ≠ 0) returns wb_data in the same cycle.
  - Undefined: the read returns the pre-write value.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with random inst.
  -> isjmp = 0, wb_en = 0, all registers read 0.
- ALU chain: ADDI r1, r0, 5; ADDI r2, r0, −3; 3 NOPs; ADD r3, r1, r2; SUB r4, r1, r2; SLT r5, r2, r1.
  -> wb_data sequence 5, 0xFFFFFFFD, 2, 8, 1, each with correct wb_dst.
- Memory: r1 = 0x40, r2 = 0xDEADBEEF, SW r2, 8(r1); 3 NOPs; LW r3, 8(r1).
  -> wb_data = 0xDEADBEEF on r3.
  - Address 0x448 aliases the same word.
- Branch: BEQ r1, r1, +4 at pc_n = 0x100.
  -> isjmp = 1 and pc_jmp = 0x110 one cycle after the instruction enters IF/ID.
  - BEQ with unequal operands -> isjmp = 0.
  - JMP imm = −1 at pc_n = 0x100 -> pc_jmp = 0xFC.
- r0: ADDI r0, r0, 7, then read r0.
  -> r0 remains 0 and wb_en for dst 0 is ignored.
- Bypass: ADDI r1, r0, 9 followed after exactly 2 NOPs by ADD r2, r1, r0.
  -> r2 = 9 with RF_BYPASS_EN, 0 without.
